// File: rtl/math_expr_pkg.sv
// rtl/math_expr_pkg.sv - shared constants, result-width helper and tag type for math_expr_sched
// Purpose: pipeline latency, result width function and the tag-pipe entry type.
// Ports: none (package).
package math_expr_pkg;

  // Latency of the math_expression core, start to valid.
  localparam int LAT = 4;

  // Tag id field is sized for the largest supported requester count (16).
  localparam int TAG_IDW = 4;

  // Result width of the core for operand width w.
  function automatic int qw(input int w);
    return 2 * w + 4;
  endfunction

  typedef struct packed {
    logic               v;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/math_expr_sched_rr_arbiter.sv
// rtl/math_expr_sched_rr_arbiter.sv - combinational round-robin arbiter
// Purpose: pick the first requester at or after ptr, wrapping modulo NREQ.
// Ports:
//   req     per-requester request
//   ptr     highest-priority index this cycle
//   en      grant enable
//   gnt     one-hot grant (zero when en low or no request)
//   winner  index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  winner
);

  logic found;

  // Two ascending passes: indices >= ptr first, then the wrapped ones below ptr.
  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (en && !found && req[i] && (IDW'(i) >= ptr)) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        winner = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (en && !found && req[i] && (IDW'(i) < ptr)) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        winner = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/math_expression.sv
// rtl/math_expression.sv - 4-stage pipeline computing q = ((3c+1)(a-b) - 4d) >>> 1
// Purpose: shared arithmetic core; one operand set accepted per cycle, result LAT cycles later.
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   start           operand set valid this cycle
//   a, b, c, d      signed W-bit operands
//   valid           result strobe, LAT cycles after start
//   q               signed QW-bit result
module math_expression
  import math_expr_pkg::*;
#(
  parameter int W  = 32,
  parameter int QW = qw(W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [W-1:0]  a,
  input  logic signed [W-1:0]  b,
  input  logic signed [W-1:0]  c,
  input  logic signed [W-1:0]  d,
  output logic                 valid,
  output logic signed [QW-1:0] q
);

  // Stage 1: a-b needs W+1 bits, 3c+1 and 4d need W+2 bits.
  logic signed [W:0]     diff1;
  logic signed [W+1:0]   tc1;
  logic signed [W+1:0]   d4_1;
  // Stage 2: product of W+2 and W+1 bit signed values fits 2W+3 bits.
  logic signed [2*W+2:0] prod2;
  logic signed [W+1:0]   d4_2;
  // Stage 3: difference fits QW = 2W+4 bits.
  logic signed [QW-1:0]  s3;
  logic [2:0]            vpipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      diff1 <= '0;
      tc1   <= '0;
      d4_1  <= '0;
      prod2 <= '0;
      d4_2  <= '0;
      s3    <= '0;
      q     <= '0;
      vpipe <= '0;
      valid <= 1'b0;
    end else begin
      diff1 <= (W+1)'(a) - (W+1)'(b);
      tc1   <= ((W+2)'(c) <<< 1) + (W+2)'(c) + (W+2)'(1);
      d4_1  <= (W+2)'(d) <<< 2;
      prod2 <= (2*W+3)'(tc1) * (2*W+3)'(diff1);
      d4_2  <= d4_1;
      s3    <= QW'(prod2) - QW'(d4_2);
      q     <= s3 >>> 1;
      vpipe <= {vpipe[1:0], start};
      valid <= vpipe[2];
    end
  end

endmodule

// File: rtl/math_expr_sched.sv
// rtl/math_expr_sched.sv - round-robin scheduler sharing one math_expression core among NREQ requesters
// Purpose: grants one operand set per cycle, tags it with the requester index, routes the result back.
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   en                    grant enable
//   req                   per-requester request, held until granted
//   op_a..op_d            packed operands, slice i belongs to requester i
//   gnt                   one-hot combinational grant
//   rsp_valid             one-hot one-cycle result strobe
//   rsp_q, rsp_id         result and its owner index (zero when no result)
//   inflight, busy        issued-but-unreturned count and its nonzero flag
//   err                   sticky tag/core valid mismatch
module math_expr_sched
  import math_expr_pkg::*;
#(
  parameter int W    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       op_a,
  input  logic [NREQ*W-1:0]       op_b,
  input  logic [NREQ*W-1:0]       op_c,
  input  logic [NREQ*W-1:0]       op_d,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rsp_valid,
  output logic signed [qw(W)-1:0] rsp_q,
  output logic [IDW-1:0]          rsp_id,
  output logic [2:0]              inflight,
  output logic                    busy,
  output logic                    err
);

  localparam int QW = qw(W);

  // Core reset synchronizer: core stays in reset until two edges after release.
  logic [1:0] rst_sync;
  logic       core_rst;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign core_rst = ~rst_sync[1];

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic           arb_en;
  logic           transfer;

  assign arb_en = en & ~core_rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .en     (arb_en),
    .gnt    (gnt),
    .winner (winner)
  );

  assign transfer = |gnt;

  logic signed [W-1:0] sel_a, sel_b, sel_c, sel_d;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    sel_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a = op_a[i*W +: W];
        sel_b = op_b[i*W +: W];
        sel_c = op_c[i*W +: W];
        sel_d = op_d[i*W +: W];
      end
    end
  end

  logic                 core_valid;
  logic signed [QW-1:0] core_q;

  math_expression #(
    .W  (W),
    .QW (QW)
  ) u_core (
    .clk   (clk),
    .rst   (core_rst),
    .start (transfer),
    .a     (sel_a),
    .b     (sel_b),
    .c     (sel_c),
    .d     (sel_d),
    .valid (core_valid),
    .q     (core_q)
  );

  // Tag pipe tracks the core pipeline one-for-one; stage LAT-1 aligns with core valid.
  tag_t tags [LAT];
  tag_t last;
  logic retire;
  logic fire;
  logic mismatch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        tags[i] <= '0;
      end
    end else begin
      tags[0] <= '{v: transfer, id: TAG_IDW'(winner)};
      for (int i = 1; i < LAT; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  assign last   = tags[LAT-1];
  assign retire = last.v;
  // While the core is held in reset its valid is meaningless; ignore it.
  assign fire     = last.v & core_valid & ~core_rst;
  assign mismatch = (last.v != core_valid) & ~core_rst;

  assign rsp_valid = fire ? ({{(NREQ-1){1'b0}}, 1'b1} << last.id) : '0;
  assign rsp_id    = fire ? IDW'(last.id) : '0;
  assign rsp_q     = fire ? core_q : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      if (transfer) begin
        rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
      end
      unique case ({transfer, retire})
        2'b10:   inflight <= inflight + 3'd1;
        2'b01:   inflight <= inflight - 3'd1;
        default: inflight <= inflight;
      endcase
      if (mismatch) begin
        err <= 1'b1;
      end
    end
  end

  assign busy = (inflight != 3'd0);

endmodule

// File: doc/math_expr_sched.md
# math_expr_sched

Round-robin scheduler that shares one `math_expression` pipeline (q = ((3c+1)(a−b) − 4d) >>> 1) between NREQ requesters. It accepts at most one operand set per cycle and tags each issue with the requester index. It routes each result back to its requester exactly LAT cycles later. It sits between the requesting engines and the single arithmetic core, which it instantiates.

## Interface
- W, 32, operand width, passed to the core
- NREQ, 4, number of requesters (2..16)
- IDW, $clog2(NREQ), requester-index width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- en  in  1  grant enable; low blocks new grants, in-flight work completes
- req  in  NREQ  per-requester request, held until granted
- op_a, op_b, op_c, op_d  in  NREQ*W each  packed signed operands, slice i belongs to requester i
- gnt  out  NREQ  one-hot grant, combinational, at most one bit set
- rsp_valid  out  NREQ  one-hot, one-cycle result strobe
- rsp_q  out  2W+4  signed result, valid with any rsp_valid bit
- rsp_id  out  IDW  index of the current result's owner
- inflight  out  3  issued-but-unreturned count, 0..LAT
- busy  out  1  inflight != 0
- err  out  1  sticky; tag/core valid mismatch detected

## Operation
- Grant: the winner is the first set bit of req at or after rr_ptr, wrapping modulo NREQ. gnt=0 when en=0, reset is asserted, or req=0.
- Transfer occurs when req[i]&gnt[i]. In that cycle the core sees start=1 and slice i of op_a..op_d. The requester may drop req or present a new operand set on the next cycle.
- rr_ptr updates on each transfer to (winner+1) mod NREQ. It is unchanged when there is no transfer.
- Tag pipe: LAT-deep shift register of {v, id}. It shifts every cycle. Stage 0 loads {transfer, winner}.
- Result: when tag stage LAT−1 has v=1 and core valid=1, assert rsp_valid[id]=1, rsp_id=id, rsp_q=core q.
- Mismatch: tag v and core valid differ. Set err (sticky until reset) and assert no rsp_valid that cycle.
- inflight: +1 on transfer, −1 on result/mismatch retire, net 0 on both in the same cycle. It never exceeds LAT.
- Core reset: the core's synchronous active-high reset is driven by ~reset through a 2-flop synchronizer, flops cleared asynchronously. Stale core valid after reset cannot produce a response because the tag pipe is already cleared.
- Reset mid-operation: all in-flight results are discarded and no rsp_valid is produced for them. rr_ptr=0.

## Timing
- Reset values: gnt=0, rsp_valid=0, rsp_q=0, rsp_id=0, inflight=0, busy=0, err=0, rr_ptr=0, tag pipe all v=0.
- LAT=4: a transfer in cycle k gives rsp_valid in cycle k+4.
- Throughput: one transfer per cycle sustained; back-to-back results in consecutive cycles.
- Responses are always accepted; there is no response backpressure.
- en falling in cycle k: no grant in cycle k; earlier transfers still return.
- First grant after reset needs reset released for ≥2 cycles (synchronizer). gnt is held 0 until the core reset is deasserted.

## Structure
- Package math_expr_pkg: LAT=4, a function qw(W)=2W+4, and a tag struct typedef {logic v; logic [IDW-1:0] id}.
- Sub-module rr_arbiter: req, ptr, en → one-hot gnt and winner index. It is purely combinational; rr_ptr lives in the parent.
- The math_expression core is instantiated once with start=|gnt.

## Test plan
- Single request: after reset, req[2] with a=10, b=4, c=2, d=1 → gnt=4'b0100 that cycle; four cycles later rsp_valid=4'b0100, rsp_id=2, rsp_q=19.
- Contention: all req held high for 8 cycles → grants 0,1,2,3,0,1,2,3. Results return in the same order, each exactly 4 cycles after its grant, with inflight saturating at 4.
- Signed/floor rounding: a=0, b=5, c=1, d=0 → −10; a=3, b=0, c=0, d=1 → −1.
- Fairness: after requester 3 is granted, req=4'b1001 → next grant is requester 0, then 3.
- en gating: en=0 with req=4'b1111 → gnt=0; in-flight results still arrive; busy falls after the last result.
- Reset mid-flight: assert reset 2 cycles after a grant → no rsp_valid afterwards, inflight=0, err=0. A new request after release returns its correct result.
